// File: rtl/sseg_scan_decoder.sv
// Recovers the hex digits shown on a multiplexed, active-low 4-digit seven-segment display
// by watching the anode/segment bus. A frame is published once every digit has been captured.

module sseg_digit_slot (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr,
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_bad,
  output logic [3:0] o_nib_view,
  output logic       o_dp_view,
  output logic       o_bad_view
);
  logic [3:0] r_nib;
  logic       r_dp;
  logic       r_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nib <= 4'h0;
      r_dp  <= 1'b0;
      r_bad <= 1'b0;
    end else if (i_wr) begin
      r_nib <= i_nib;
      r_dp  <= i_dp;
      r_bad <= i_bad;
    end
  end

  // The view forwards a same-cycle write so the completing digit lands in the frame.
  assign o_nib_view = i_wr ? i_nib : r_nib;
  assign o_dp_view  = i_wr ? i_dp  : r_dp;
  assign o_bad_view = i_wr ? i_bad : r_bad;
endmodule

module sseg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] hex,
  output logic [3:0]  dp,
  output logic [3:0]  bad,
  output logic        frame_valid,
  output logic        multi_an,
  output logic        stale
);
  localparam int NUM_DIGITS = 4;
  localparam int SC_W       = 8;
  localparam int TO_W       = 24;
  localparam logic [SC_W-1:0] STABLE_MAX  = SC_W'(STABLE_CYCLES);
  localparam logic [SC_W-1:0] STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX      = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

  logic [11:0]           r_in;
  logic [SC_W-1:0]       r_stab;
  logic [TO_W-1:0]       r_to;
  logic [NUM_DIGITS-1:0] r_seen;
  logic [15:0]           r_hex;
  logic [3:0]            r_dp;
  logic [3:0]            r_bad;
  logic                  r_fv;
  logic                  r_multi;
  logic                  r_stale;

  logic                  w_same;
  logic                  w_reach;
  logic [2:0]            w_nlow;
  logic                  w_cap;
  logic                  w_done;
  logic                  w_timeout;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [NUM_DIGITS-1:0] w_seen_nxt;
  logic [3:0]            w_dec_nib;
  logic                  w_dec_ok;

  logic [NUM_DIGITS-1:0][3:0] w_view_nib;
  logic [NUM_DIGITS-1:0]      w_view_dp;
  logic [NUM_DIGITS-1:0]      w_view_bad;

  assign w_same  = ({an, sseg} == r_in);
  assign w_reach = w_same && (r_stab == STABLE_LAST);

  always_comb begin
    w_nlow = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) w_nlow = w_nlow + {2'b00, ~an[i]};
  end

  // A blank (no anode low) interval falls through both the capture and multi-anode paths.
  assign w_cap      = w_reach && (w_nlow == 3'd1);
  assign w_sel      = w_cap ? ~an : '0;
  assign w_seen_nxt = r_seen | w_sel;
  assign w_done     = w_cap && (w_seen_nxt == 4'hF);
  assign w_timeout  = !w_cap && (r_to == TO_LAST);

  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_nib = 4'h0;
    case (sseg[6:0])
      7'b0000001: w_dec_nib = 4'h0;
      7'b1001111: w_dec_nib = 4'h1;
      7'b0010010: w_dec_nib = 4'h2;
      7'b0000110: w_dec_nib = 4'h3;
      7'b1001100: w_dec_nib = 4'h4;
      7'b0100100: w_dec_nib = 4'h5;
      7'b0100000: w_dec_nib = 4'h6;
      7'b0001111: w_dec_nib = 4'h7;
      7'b0000000: w_dec_nib = 4'h8;
      7'b0000100: w_dec_nib = 4'h9;
      7'b0001000: w_dec_nib = 4'hA;
      7'b1100000: w_dec_nib = 4'hB;
      7'b0110001: w_dec_nib = 4'hC;
      7'b1000010: w_dec_nib = 4'hD;
      7'b0110000: w_dec_nib = 4'hE;
      7'b0111000: w_dec_nib = 4'hF;
      default:    w_dec_ok  = 1'b0;
    endcase
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    sseg_digit_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .i_wr      (w_sel[g]),
      .i_nib     (w_dec_nib),
      .i_dp      (sseg[7]),
      .i_bad     (!w_dec_ok),
      .o_nib_view(w_view_nib[g]),
      .o_dp_view (w_view_dp[g]),
      .o_bad_view(w_view_bad[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in   <= '0;
      r_stab <= '0;
    end else begin
      r_in <= {an, sseg};
      if (!w_same)                 r_stab <= '0;
      else if (r_stab != STABLE_MAX) r_stab <= r_stab + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to    <= '0;
      r_seen  <= '0;
      r_hex   <= '0;
      r_dp    <= '0;
      r_bad   <= '0;
      r_fv    <= 1'b0;
      r_multi <= 1'b0;
      r_stale <= 1'b0;
    end else begin
      r_fv <= w_done;
      if (w_cap)              r_to <= '0;
      else if (r_to != TO_MAX) r_to <= r_to + 1'b1;

      if (w_reach && (w_nlow >= 3'd2)) r_multi <= 1'b1;

      if (w_done) begin
        r_hex   <= w_view_nib;
        r_dp    <= w_view_dp;
        r_bad   <= w_view_bad;
        r_seen  <= '0;
        r_stale <= 1'b0;
      end else if (w_timeout) begin
        r_seen  <= '0;
        r_stale <= 1'b1;
      end else begin
        r_seen <= w_seen_nxt;
      end
    end
  end

  assign hex         = r_hex;
  assign dp          = r_dp;
  assign bad         = r_bad;
  assign frame_valid = r_fv;
  assign multi_an    = r_multi;
  assign stale       = r_stale;
endmodule
